// File: rtl/mult_arbiter.sv
// Round-robin arbiter that shares one sequential multiplier among N_REQ requesters.
// It grants one request, waits for the product or a timeout, then holds the response until it is accepted.
module mult_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 127,
  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [N_REQ*WIDTH-1:0]   i_req_a,
  input  logic [N_REQ*WIDTH-1:0]   i_req_b,
  output logic [N_REQ-1:0]         o_req_ready,
  output logic                     o_mul_start,
  output logic [WIDTH-1:0]         o_mul_a,
  output logic [WIDTH-1:0]         o_mul_b,
  input  logic                     i_mul_done,
  input  logic [2*WIDTH-1:0]       i_mul_result,
  output logic                     o_rsp_valid,
  output logic [ID_W-1:0]          o_rsp_id,
  output logic [2*WIDTH-1:0]       o_rsp_result,
  output logic                     o_rsp_err,
  input  logic                     i_rsp_ready,
  output logic                     o_busy
);

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t                 state_reg, state_next;
  logic [ID_W-1:0]        last_grant_reg, last_grant_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [N_REQ-1:0]       req_ready_reg, req_ready_next;
  logic                   mul_start_reg, mul_start_next;
  logic [WIDTH-1:0]       mul_a_reg, mul_a_next;
  logic [WIDTH-1:0]       mul_b_reg, mul_b_next;
  logic                   rsp_valid_reg, rsp_valid_next;
  logic [ID_W-1:0]        rsp_id_reg, rsp_id_next;
  logic [2*WIDTH-1:0]     rsp_result_reg, rsp_result_next;
  logic                   rsp_err_reg, rsp_err_next;

  logic [WIDTH-1:0]       req_a_arr [N_REQ];
  logic [WIDTH-1:0]       req_b_arr [N_REQ];
  logic [ID_W-1:0]        cand [N_REQ];
  logic                   win_found;
  logic [ID_W-1:0]        win_idx;

  // cand[k] is the requester examined at search offset k+1 after the last grant.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign req_a_arr[gi] = i_req_a[gi*WIDTH +: WIDTH];
      assign req_b_arr[gi] = i_req_b[gi*WIDTH +: WIDTH];
      assign cand[gi]      = ID_W'((int'(last_grant_reg) + gi + 1) % N_REQ);
    end
  endgenerate

  // Scan from the farthest offset down so the nearest valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_grant_reg;
    for (int k = N_REQ; k >= 1; k--) begin
      if (i_req_valid[cand[k-1]]) begin
        win_found = 1'b1;
        win_idx   = cand[k-1];
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    cnt_next        = cnt_reg;
    req_ready_next  = '0;
    mul_start_next  = 1'b0;
    mul_a_next      = mul_a_reg;
    mul_b_next      = mul_b_reg;
    rsp_valid_next  = rsp_valid_reg;
    rsp_id_next     = rsp_id_reg;
    rsp_result_next = rsp_result_reg;
    rsp_err_next    = rsp_err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (win_found) begin
          state_next      = ST_WAIT;
          last_grant_next = win_idx;
          cnt_next        = '0;
          mul_a_next      = req_a_arr[win_idx];
          mul_b_next      = req_b_arr[win_idx];
          req_ready_next  = N_REQ'(1) << win_idx;
          mul_start_next  = 1'b1;
        end
      end
      ST_WAIT: begin
        // A completion arriving on the limit cycle takes precedence over the timeout.
        if (i_mul_done) begin
          state_next      = ST_RESP;
          rsp_valid_next  = 1'b1;
          rsp_id_next     = last_grant_reg;
          rsp_result_next = i_mul_result;
          rsp_err_next    = 1'b0;
        end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          state_next      = ST_RESP;
          rsp_valid_next  = 1'b1;
          rsp_id_next     = last_grant_reg;
          rsp_result_next = '0;
          rsp_err_next    = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_valid_reg && i_rsp_ready) begin
          state_next     = ST_IDLE;
          rsp_valid_next = 1'b0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= ID_W'(N_REQ - 1);
      cnt_reg        <= '0;
      req_ready_reg  <= '0;
      mul_start_reg  <= 1'b0;
      mul_a_reg      <= '0;
      mul_b_reg      <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= '0;
      rsp_result_reg <= '0;
      rsp_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      cnt_reg        <= cnt_next;
      req_ready_reg  <= req_ready_next;
      mul_start_reg  <= mul_start_next;
      mul_a_reg      <= mul_a_next;
      mul_b_reg      <= mul_b_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_id_reg     <= rsp_id_next;
      rsp_result_reg <= rsp_result_next;
      rsp_err_reg    <= rsp_err_next;
    end
  end

  assign o_req_ready  = req_ready_reg;
  assign o_mul_start  = mul_start_reg;
  assign o_mul_a      = mul_a_reg;
  assign o_mul_b      = mul_b_reg;
  assign o_rsp_valid  = rsp_valid_reg;
  assign o_rsp_id     = rsp_id_reg;
  assign o_rsp_result = rsp_result_reg;
  assign o_rsp_err    = rsp_err_reg;
  assign o_busy       = (state_reg != ST_IDLE);

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one sequential multiplier; legal range 2..8.
REQ-002 Parameter WIDTH, default 32: operand width; product width is 2*WIDTH.
REQ-003 Parameter TIMEOUT, default 127: maximum WAIT cycles allowed before the block forces an error response; legal range 1..255.
REQ-004 i_clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 i_rst  input  1  reset; synchronous and active-high.
REQ-006 i_req_valid  input  N_REQ  per-requester request valid.
REQ-007 i_req_a  input  N_REQ*WIDTH  packed operand A; requester k occupies [k*WIDTH +: WIDTH].
REQ-008 i_req_b  input  N_REQ*WIDTH  packed operand B, packed the same way as i_req_a.
REQ-009 o_req_ready  output  N_REQ  one-hot, one-cycle accept pulse to the granted requester.
REQ-010 o_mul_start  output  1  one-cycle start pulse to the shared multiplier.
REQ-011 o_mul_a, o_mul_b  output  WIDTH each  latched operands for the multiplier.
REQ-012 i_mul_done  input  1  one-cycle completion pulse from the multiplier.
REQ-013 i_mul_result  input  2*WIDTH  product; valid in the i_mul_done cycle.
REQ-014 o_rsp_valid  output  1  response valid.
REQ-015 o_rsp_id  output  ID_W = ceil(log2(N_REQ))  index of the requester that owns the response.
REQ-016 o_rsp_result  output  2*WIDTH  returned product.
REQ-017 o_rsp_err  output  1  response terminated by timeout.
REQ-018 i_rsp_ready  input  1  consumer accepts the response.
REQ-019 o_busy  output  1  high whenever state is not IDLE.

Function
REQ-020 FSM states: IDLE, WAIT, RESP; all outputs registered.
REQ-021 IDLE, no request valid: remain in IDLE.
REQ-022 IDLE, any i_req_valid high at edge t:
- select the round-robin winner w;
- latch its operands into o_mul_a/o_mul_b;
- in cycle t+1: o_req_ready[w]=1, o_mul_start=1, both for exactly one cycle;
- state moves to WAIT.
REQ-023 Round-robin search starts at last_grant+1 and wraps modulo N_REQ; last_grant updates to w at grant.
REQ-024 A requester SHALL hold valid and operands stable until it sees its ready pulse; a valid dropped before grant is not served.
REQ-025 o_mul_a/o_mul_b SHALL stay stable from grant until the next grant.
REQ-026 WAIT, on i_mul_done:
- capture i_mul_result into o_rsp_result and w into o_rsp_id;
- set o_rsp_err=0 and o_rsp_valid=1 next cycle;
- state moves to RESP.
REQ-027 WAIT cycle counter clears on entry and increments every WAIT cycle without i_mul_done.
REQ-028 WAIT timeout: after TIMEOUT cycles without i_mul_done, o_rsp_result=0, o_rsp_err=1, o_rsp_valid=1, state moves to RESP.
REQ-029 i_mul_done in the same cycle as the timeout limit: done wins and no error is flagged.
REQ-030 RESP: o_rsp_valid, o_rsp_id, o_rsp_result and o_rsp_err SHALL hold stable until i_rsp_ready=1.
REQ-031 RESP handshake: the cycle after o_rsp_valid and i_rsp_ready are both high, o_rsp_valid=0 and state returns to IDLE.
REQ-032 Minimum gap between successive grants is 1 IDLE cycle.
REQ-033 i_mul_done outside WAIT is ignored: no state or output change.
REQ-034 i_rsp_ready while o_rsp_valid=0 is ignored.
REQ-035 Requests arriving while busy are not accepted and wait for the return to IDLE; no ready pulse is issued while busy.

Reset
REQ-036 With i_rst high at an edge, the following take effect the next cycle:
- state=IDLE, last_grant=N_REQ-1 (requester 0 wins first), counter=0;
- o_req_ready=0, o_mul_start=0, o_mul_a=0, o_mul_b=0;
- o_rsp_valid=0, o_rsp_id=0, o_rsp_result=0, o_rsp_err=0, o_busy=0.
REQ-037 Reset mid-operation (WAIT or RESP) SHALL abort the transaction with no response; the system resets the multiplier on the same i_rst.
REQ-038 Reset has priority over every other input in the same cycle.

Verification
REQ-039 Single request: only req 2 valid, a=12, b=13; model returns 156 after 100 cycles -> one ready pulse on bit 2, one start, then response id=2, result=156, err=0.
REQ-040 Fairness: all four valid continuously from reset with an instant-ready consumer -> grant order 0,1,2,3,0,1.
REQ-041 Backpressure: i_rsp_ready low for 5 cycles in RESP -> response held unchanged, no o_mul_start, accepted on the 6th cycle.
REQ-042 Timeout: TIMEOUT=10, i_mul_done never asserted -> response after 10 WAIT cycles with err=1 and result=0; done and limit in the same cycle -> err=0.
REQ-043 Reset mid-WAIT: i_rst after a grant to req 1 -> all outputs zero next cycle, no response; next grant with all requesters valid goes to req 0.
REQ-044 Spurious done: i_mul_done pulsed in IDLE and in RESP -> no state or output change.
